fifo_stim_driver: RTL and testbench

Synthesizable stimulus driver for the FIFO interface. It drives the write and read sides of the synchronous FIFO (`wr_en`, `rd_en`, `data_in`) with deterministic LFSR-based traffic in selectable sequences, and checks the FIFO's `full`/`empty` flags at sequence boundaries. It sits opposite the FIFO monitor: the driver generates traffic and the monitor observes it. It replaces testbench-only stimulus in FPGA/emulation builds and signals `done` in place of `test_finished`.

---
 rtl/fifo_stim_driver.sv | 137 +++++++++++++
 tb/tb_fifo_stim_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_stim_driver.sv
// fifo_stim_driver: LFSR traffic sequencer for a synchronous FIFO with full/empty checks at phase ends; FIFO_STIM_PROBE_EN adds mode 2 overflow/underflow probing.
// Latency: first enable one cycle after start is accepted; done the cycle after the last active phase cycle.
// Backpressure: none; enables are issued blind and full/empty are checked, never obeyed.
module fifo_stim_driver #(
    parameter int          FIFO_WIDTH = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          NUM_TXN    = 1000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  full,
    input  logic                  empty,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  seq_err,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
);
    localparam int MAX_LEN = (FIFO_DEPTH > NUM_TXN) ? FIFO_DEPTH : NUM_TXN;
    localparam int CW      = $clog2(MAX_LEN) + 1;
    localparam logic [CW-1:0] LAST_D = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] LAST_N = CW'(NUM_TXN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_OVF, S_DRAIN, S_UNF, S_MIXED, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] phase_cnt;
    logic [15:0]   lfsr, lfsr_nxt;
    logic          accept;
    logic          chk_full_pend, chk_empty_pend;
    logic          flag_fail;
`ifdef FIFO_STIM_PROBE_EN
    logic          probe_q;
`endif

    assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    generate
        if (FIFO_WIDTH > 16) begin : g_ext
            assign data_in = {{(FIFO_WIDTH-16){1'b0}}, lfsr};
        end else begin : g_trunc
            assign data_in = lfsr[FIFO_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = (mode == 2'd1) ? S_MIXED : S_FILL;
            S_FILL: if (phase_cnt == LAST_D) begin
`ifdef FIFO_STIM_PROBE_EN
                state_nxt = probe_q ? S_OVF : S_DRAIN;
`else
                state_nxt = S_DRAIN;
`endif
            end
`ifdef FIFO_STIM_PROBE_EN
            S_OVF:  if (phase_cnt == CW'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (phase_cnt == LAST_D) state_nxt = probe_q ? S_UNF : S_DONE;
            S_UNF:  if (phase_cnt == CW'(1)) state_nxt = S_DONE;
`else
            S_DRAIN: if (phase_cnt == LAST_D) state_nxt = S_DONE;
`endif
            S_MIXED: if (phase_cnt == LAST_N) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE) && (state != S_DONE);
        done  = (state == S_DONE);
        wr_en = (state == S_FILL) || ((state == S_MIXED) && lfsr[0]);
        rd_en = (state == S_DRAIN) || ((state == S_MIXED) && lfsr[1]);
`ifdef FIFO_STIM_PROBE_EN
        wr_en = wr_en || (state == S_OVF);
        rd_en = rd_en || (state == S_UNF);
`endif
    end

    // Phase-end checks sample the flag one edge after the final write/read lands in the FIFO.
    always_comb begin
        flag_fail = (chk_full_pend && !full) || (chk_empty_pend && !empty);
`ifdef FIFO_STIM_PROBE_EN
        flag_fail = flag_fail || ((state == S_OVF) && !full) || ((state == S_UNF) && !empty);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr           <= SEED;
            phase_cnt      <= '0;
            wr_count       <= '0;
            rd_count       <= '0;
            seq_err        <= 1'b0;
            chk_full_pend  <= 1'b0;
            chk_empty_pend <= 1'b0;
`ifdef FIFO_STIM_PROBE_EN
            probe_q        <= 1'b0;
`endif
        end else if (accept) begin
            lfsr           <= SEED;
            phase_cnt      <= '0;
            wr_count       <= '0;
            rd_count       <= '0;
            seq_err        <= 1'b0;
            chk_full_pend  <= 1'b0;
            chk_empty_pend <= 1'b0;
`ifdef FIFO_STIM_PROBE_EN
            probe_q        <= (mode == 2'd2);
`endif
        end else begin
            if (busy) begin
                lfsr      <= lfsr_nxt;
                phase_cnt <= (state_nxt != state) ? '0 : phase_cnt + CW'(1);
            end
            if (wr_en && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
            if (rd_en && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
            chk_full_pend  <= (state == S_FILL)  && (state_nxt != S_FILL);
            chk_empty_pend <= (state == S_DRAIN) && (state_nxt != S_DRAIN);
            if (flag_fail) seq_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_stim_driver.sv
// Bench for fifo_stim_driver: per-sequence vector table plus abort and held-start sequences against a small FIFO occupancy model.
module tb_fifo_stim_driver;
    localparam int          D    = 8;
    localparam int          N    = 20;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic [1:0]  mode;
        logic        stuck;
        int          wr_len;
        int          done_cyc;
        logic [15:0] wcnt;
        logic [15:0] rcnt;
        logic        err;
    } vec_t;

    logic        clk, rst, start, full, empty, full_stuck;
    logic [1:0]  mode;
    logic        wr_en, rd_en, busy, done, seq_err;
    logic [15:0] data_in, wr_count, rd_count;
    int          occ;
    int          n_checks = 0;
    int          n_errors = 0;
    string       cur = "";
    vec_t        vecs [5];

    fifo_stim_driver #(.FIFO_WIDTH(16), .FIFO_DEPTH(D), .NUM_TXN(N), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .full(full), .empty(empty),
        .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .busy(busy), .done(done),
        .seq_err(seq_err), .wr_count(wr_count), .rd_count(rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO occupancy model; full can be forced low to emulate a broken flag.
    assign full  = full_stuck ? 1'b0 : (occ == D);
    assign empty = (occ == 0);
    always @(posedge clk or posedge rst) begin
        if (rst) occ <= 0;
        else     occ <= occ + ((wr_en && occ != D) ? 1 : 0) - ((rd_en && occ != 0) ? 1 : 0);
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", cur, name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("wr_en", 32'(wr_en), 32'd0);
        check("rd_en", 32'(rd_en), 32'd0);
        check("busy", 32'(busy), 32'd0);
        check("done", 32'(done), 32'd0);
        check("seq_err", 32'(seq_err), 32'd0);
        check("data_in", 32'(data_in), 32'(SEED));
        check("wr_count", 32'(wr_count), 32'd0);
        check("rd_count", 32'(rd_count), 32'd0);
    endtask

    task automatic run_seq(input vec_t v);
        logic [15:0] ref_l;
        logic [15:0] first3 [3];
        logic        exp_wr, exp_rd;
        first3 = '{16'hACE1, 16'hE270, 16'h7138};
        ref_l  = SEED;
        @(negedge clk);
        full_stuck = v.stuck;
        mode  = v.mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < v.done_cyc; k++) begin
            if (v.mode == 2'd1) begin
                exp_wr = ref_l[0];
                exp_rd = ref_l[1];
            end else begin
                exp_wr = (k <= v.wr_len);
                exp_rd = !exp_wr;
            end
            check($sformatf("c%0d wr_en", k), 32'(wr_en), 32'(exp_wr));
            check($sformatf("c%0d rd_en", k), 32'(rd_en), 32'(exp_rd));
            check($sformatf("c%0d data_in", k), 32'(data_in), 32'(ref_l));
            check($sformatf("c%0d busy", k), 32'(busy), 32'd1);
            if (k == 1) begin
                check("c1 seq_err clr", 32'(seq_err), 32'd0);
                check("c1 wr_count clr", 32'(wr_count), 32'd0);
                check("c1 rd_count clr", 32'(rd_count), 32'd0);
            end
            if (v.mode != 2'd1 && k <= 3)
                check($sformatf("write%0d data", k), 32'(data_in), 32'(first3[k-1]));
            ref_l = lfsr_step(ref_l);
            @(negedge clk);
        end
        check("done at end", 32'(done), 32'd1);
        check("busy at end", 32'(busy), 32'd0);
        check("wr_count", 32'(wr_count), 32'(v.wcnt));
        check("rd_count", 32'(rd_count), 32'(v.rcnt));
        check("seq_err at done", 32'(seq_err), 32'(v.err));
        repeat (3) @(negedge clk);
        check("done held", 32'(done), 32'd1);
        check("seq_err sticky", 32'(seq_err), 32'(v.err));
        full_stuck = 1'b0;
    endtask

    initial begin
        logic [15:0] l;
        logic [15:0] mw, mr;
        rst = 1'b1; start = 1'b0; mode = 2'd0; full_stuck = 1'b0;
        l = SEED; mw = '0; mr = '0;
        for (int i = 0; i < N; i++) begin
            mw = mw + 16'(l[0]);
            mr = mr + 16'(l[1]);
            l  = lfsr_step(l);
        end
        vecs[0] = '{mode: 2'd0, stuck: 1'b0, wr_len: 8,  done_cyc: 17, wcnt: 16'd8,  rcnt: 16'd8,  err: 1'b0};
`ifdef FIFO_STIM_PROBE_EN
        vecs[1] = '{mode: 2'd2, stuck: 1'b0, wr_len: 10, done_cyc: 21, wcnt: 16'd10, rcnt: 16'd10, err: 1'b0};
`else
        vecs[1] = '{mode: 2'd2, stuck: 1'b0, wr_len: 8,  done_cyc: 17, wcnt: 16'd8,  rcnt: 16'd8,  err: 1'b0};
`endif
        vecs[2] = '{mode: 2'd0, stuck: 1'b1, wr_len: 8,  done_cyc: 17, wcnt: 16'd8,  rcnt: 16'd8,  err: 1'b1};
        vecs[3] = '{mode: 2'd3, stuck: 1'b0, wr_len: 8,  done_cyc: 17, wcnt: 16'd8,  rcnt: 16'd8,  err: 1'b0};
        vecs[4] = '{mode: 2'd1, stuck: 1'b0, wr_len: 0,  done_cyc: 21, wcnt: mw,     rcnt: mr,     err: 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cur = "reset";
        check_reset_vals();

        for (int i = 0; i < 5; i++) begin
            cur = $sformatf("vec%0d", i);
            run_seq(vecs[i]);
        end

        // Reset in cycle 5 of a fill/drain sequence, then replay from the seed.
        cur = "abort";
        @(negedge clk);
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy c5", 32'(busy), 32'd1);
        check("wr_count c5", 32'(wr_count), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals();
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);
        check("idle wr_en", 32'(wr_en), 32'd0);
        cur = "replay";
        run_seq(vecs[0]);

        // start held high across a whole sequence and into the next one.
        cur = "held";
        @(negedge clk);
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        check("c10 wr_count", 32'(wr_count), 32'd8);
        check("c10 rd_count", 32'(rd_count), 32'd1);
        check("c10 busy", 32'(busy), 32'd1);
        repeat (7) @(negedge clk);
        check("c17 done", 32'(done), 32'd1);
        check("c17 wr_count", 32'(wr_count), 32'd8);
        @(negedge clk);
        check("restart busy", 32'(busy), 32'd1);
        check("restart done", 32'(done), 32'd0);
        check("restart wr_count", 32'(wr_count), 32'd0);
        check("restart rd_count", 32'(rd_count), 32'd0);
        check("restart wr_en", 32'(wr_en), 32'd1);
        check("restart data_in", 32'(data_in), 32'hACE1);
        start = 1'b0;
        for (int k = 0; k < 40 && !done; k++) @(negedge clk);
        check("second done", 32'(done), 32'd1);
        check("second seq_err", 32'(seq_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end
endmodule
